fp16_multiplier: RTL and testbench
==================================

Name: fp16_multiplier

Overview:
- Pipelined IEEE 754 binary16 (half-precision) multiplier: out = a × b.
- It is the multiply stage of the FP16 MAC unit; its product feeds the FP16 adder/accumulator.
- Fixed 2-cycle latency, one operation accepted per cycle, valid-tagged.
- Computes full IEEE special-case handling, round-to-nearest-even, and status flags.

Parameters:
- None. Format is fixed: 1 sign bit, 5 exponent bits (bias 15), 10 fraction bits.

Ports:
- clk  in  1  system clock, rising-edge active
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  a/b are valid this cycle
- a  in  16  operand A, binary16
- b  in  16  operand B, binary16
- out_valid  out  1  out/flags are valid; in_valid delayed exactly 2 cycles
- out  out  16  product, binary16
- flag_invalid  out  1  NaN generated or NaN operand
- flag_overflow  out  1  result rounded to ±inf from finite operands
- flag_underflow  out  1  tiny (result subnormal or zero) and inexact
- flag_inexact  out  1  rounded result differs from exact product

Behaviour:
- Interface: one clock and one reset; reset is synchronous and active-high.
- Reset (rst=1 at a clk edge): all pipeline registers clear. out=0x0000, out_valid=0, all flags=0.
- rst has priority over in_valid. Any operations in flight when reset asserts are discarded and do not emerge afterwards.
- Pipeline:
  - Stage 1 (edge N): unpack both operands, classify them, form sign = a[15]^b[15], form the 11×11 significand product (22 bits), and form the exponent sum ea+eb-15 in a signed 7-bit field.
  - Stage 2 (edge N+1): normalize, apply RNE, handle denormalization and overflow, pack, and compute flags.
  - out_valid is high in the cycle after edge N+1.
- Throughput: 1 per cycle, no stall and no backpressure.
- When out_valid=0, out and the flags hold their last values. They are don't-care to consumers.
- Unpacking:
  - Exponent 0 means subnormal: implicit bit 0, effective exponent 1.
  - Exponent 31 with fraction 0 is infinity; with fraction nonzero it is NaN.
- Normalization: the 22-bit product lies in [0,4). If bit 21 is set, shift right 1 and increment the exponent. Subnormal inputs use a leading-zero count to left-normalize.
- Rounding: round-to-nearest-even, using guard, round and sticky bits (sticky = OR of all lower bits). If rounding carries out of the mantissa, renormalize.
- Underflow:
  - If the unbiased result is below the subnormal range, shift right with the sticky bit preserved, then round.
  - The result may round up to the minimum normal, 0x0400.
  - A result below half of the minimum subnormal gives signed zero, with inexact and underflow set.
- Overflow: a biased exponent of 31 or more after rounding gives ±inf (0x7C00 | sign<<15), with overflow and inexact set.
- Special cases:
  - Any NaN operand, or inf × 0, gives the canonical quiet NaN 0x7E00 with invalid set. The sign is ignored.
  - inf × finite nonzero gives signed inf, no flags.
  - 0 × finite gives signed zero, no flags.
- Sign of zero and inf results is always a[15]^b[15].

Decomposition:
- Shared package fp16_pkg holds:
  - Constants: EXP_W=5, FRAC_W=10, BIAS=15, QNAN=16'h7E00, PINF=16'h7C00.
  - Typedefs: a packed fp16_t struct {sign, exp, frac} and a classification enum {ZERO, SUBNORM, NORMAL, INF, NAN}.
- One natural sub-module, fp16_round_pack: takes sign, a signed exponent, and the significand with guard/round/sticky bits. It returns the packed result plus the overflow, underflow and inexact flags. It is reused by the adder.

Test Plan:
- a=0x3800 (0.5), b=0x3800 → out=0x3400 (0.25), no flags, out_valid exactly 2 cycles after in_valid.
- a=0xC100 (-2.5), b=0x3D00 (1.25) → 0xC240 (-3.125). Then a=0xC100, b=0xBD00 → 0x4240.
- a=0x7BFF, b=0x4000 → 0x7C00 with overflow and inexact. a=0x7C00, b=0x0000 → 0x7E00 with invalid. a=0x7E00, b=0x3C00 → 0x7E00 with invalid.
- Subnormals:
  - a=0x0400, b=0x3800 → 0x0200, no flags.
  - a=0x0001, b=0x3C00 → 0x0001.
  - a=0x0001, b=0x3800 → 0x0000 (tie to even) with underflow and inexact.
- Rounding: a=0x3C01, b=0x3C01 → 0x3C02 with inexact.
- Streaming and reset:
  - Back-to-back in_valid for 8 cycles → 8 consecutive correct results in order.
  - Assert rst while 2 operations are in flight → out_valid=0 and out=0x0000 next cycle; no stale result appears after rst is released.

Source files
------------

// File: rtl/fp16_pkg.sv
// Shared binary16 definitions: field widths, special encodings, operand classification.
package fp16_pkg;
  localparam int EXP_W = 5;
  localparam int FRAC_W = 10;
  localparam int BIAS = 15;
  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] PINF = 16'h7C00;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp16_t;

  typedef enum logic [2:0] {ZERO, SUBNORM, NORMAL, INF, NAN} fp16_class_t;

  function automatic fp16_class_t classify(input fp16_t x);
    if (x.exp == '0) return (x.frac == '0) ? ZERO : SUBNORM;
    if (x.exp == '1) return (x.frac == '0) ? INF : NAN;
    return NORMAL;
  endfunction
endpackage

// File: rtl/fp16_multiplier_if.sv
// Operand/result bundle of the FP16 multiplier; master drives operands, slave returns results.
interface fp16_multiplier_if;
  logic        in_valid;
  logic [15:0] a;
  logic [15:0] b;
  logic        out_valid;
  logic [15:0] out;
  logic        flag_invalid;
  logic        flag_overflow;
  logic        flag_underflow;
  logic        flag_inexact;

  modport master (
    output in_valid, a, b,
    input  out_valid, out, flag_invalid, flag_overflow, flag_underflow, flag_inexact
  );

  modport slave (
    input  in_valid, a, b,
    output out_valid, out, flag_invalid, flag_overflow, flag_underflow, flag_inexact
  );
endinterface

// File: rtl/fp16_round_pack.sv
// Rounds a normalized significand (leading 1, 10 fraction bits, guard/round/sticky) to binary16
// with RNE, denormalizing tiny results and saturating overflow to signed infinity.
module fp16_round_pack (
  input  logic              sign,
  input  logic signed [7:0] exp,
  input  logic [13:0]       sig,
  output logic [15:0]       result,
  output logic              overflow,
  output logic              underflow,
  output logic              inexact
);
  import fp16_pkg::*;

  logic [7:0]  dshift;
  logic [3:0]  sh;
  logic [26:0] wide;
  logic [12:0] low;
  logic [7:0]  exp_u;
  logic        rup;
  logic        lost_any;
  logic [17:0] rounded;

  always_comb begin
    dshift = '0;
    sh     = '0;
    wide   = '0;
    exp_u  = '0;
    low    = sig[12:0];
    if (exp < 8'sd1) begin
      // Beyond 14 places every bit is already in the sticky position.
      dshift = 8'(8'sd1 - exp);
      sh     = (dshift > 8'd14) ? 4'd14 : dshift[3:0];
      wide   = 27'({sig, 14'b0} >> sh);
      low    = {wide[26:15], wide[14] | (|wide[13:0])};
    end else begin
      exp_u = $unsigned(exp);
    end
    lost_any = |low[2:0];
    rup      = low[2] & (low[1] | low[0] | low[3]);
    // Carry out of the fraction lands in the exponent field, renormalizing for free.
    rounded  = {exp_u, low[12:3]} + 18'(rup);
    if (rounded[17:10] >= 8'd31) begin
      result    = {sign, PINF[14:0]};
      overflow  = 1'b1;
      underflow = 1'b0;
      inexact   = 1'b1;
    end else begin
      result    = {sign, rounded[14:0]};
      overflow  = 1'b0;
      inexact   = lost_any;
      underflow = lost_any && (rounded[17:10] == 8'd0);
    end
  end
endmodule

// File: rtl/fp16_multiplier.sv
// Two-stage binary16 multiplier: unpack/multiply, then normalize/round/pack with IEEE flags.
module fp16_multiplier (
  input logic              clk,
  input logic              rst,
  fp16_multiplier_if.slave bus
);
  import fp16_pkg::*;

  function automatic logic [4:0] lzc22(input logic [21:0] v);
    lzc22 = 5'd22;
    for (int i = 0; i < 22; i++) if (v[i]) lzc22 = 5'(21 - i);
  endfunction

  fp16_t             op_a, op_b;
  fp16_class_t       cls_a, cls_b;
  logic [4:0]        eff_exp_a, eff_exp_b;
  logic [10:0]       sig_a, sig_b;
  logic              sign_c, spec_c, invalid_c;
  logic [21:0]       prod_c;
  logic signed [6:0] exp_sum_c;
  logic [15:0]       spec_val_c;

  assign op_a = bus.a;
  assign op_b = bus.b;

  always_comb begin
    cls_a      = classify(op_a);
    cls_b      = classify(op_b);
    eff_exp_a  = (op_a.exp == '0) ? 5'd1 : op_a.exp;
    eff_exp_b  = (op_b.exp == '0) ? 5'd1 : op_b.exp;
    sig_a      = {op_a.exp != '0, op_a.frac};
    sig_b      = {op_b.exp != '0, op_b.frac};
    prod_c     = 22'(sig_a) * 22'(sig_b);
    exp_sum_c  = $signed({2'b00, eff_exp_a}) + $signed({2'b00, eff_exp_b}) - $signed(7'(BIAS));
    sign_c     = op_a.sign ^ op_b.sign;
    spec_c     = 1'b1;
    invalid_c  = 1'b0;
    spec_val_c = '0;
    if (cls_a == NAN || cls_b == NAN || (cls_a == INF && cls_b == ZERO) ||
        (cls_a == ZERO && cls_b == INF)) begin
      spec_val_c = QNAN;
      invalid_c  = 1'b1;
    end else if (cls_a == INF || cls_b == INF) begin
      spec_val_c = {sign_c, PINF[14:0]};
    end else if (cls_a == ZERO || cls_b == ZERO) begin
      spec_val_c = {sign_c, 15'd0};
    end else begin
      spec_c = 1'b0;
    end
  end

  // ---- stage 1: unpacked product ----
  logic              vld_p1, sign_p1, spec_p1, invalid_p1;
  logic [21:0]       prod_p1;
  logic signed [6:0] exp_p1;
  logic [15:0]       spec_val_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1      <= 1'b0;
      sign_p1     <= 1'b0;
      spec_p1     <= 1'b0;
      invalid_p1  <= 1'b0;
      prod_p1     <= '0;
      exp_p1      <= '0;
      spec_val_p1 <= '0;
    end else begin
      vld_p1      <= bus.in_valid;
      sign_p1     <= sign_c;
      spec_p1     <= spec_c;
      invalid_p1  <= invalid_c;
      prod_p1     <= prod_c;
      exp_p1      <= exp_sum_c;
      spec_val_p1 <= spec_val_c;
    end
  end

  logic [4:0]        lz_c;
  logic [21:0]       norm_c;
  logic signed [7:0] exp_norm_c;
  logic [13:0]       grs_sig_c;
  logic [15:0]       rp_result;
  logic              rp_ovf, rp_unf, rp_inx;

  // Left-justify the leading 1 at bit 21; bit 21 carries weight 2^1 of the raw product.
  assign lz_c       = lzc22(prod_p1);
  assign norm_c     = prod_p1 << lz_c;
  assign exp_norm_c = $signed({exp_p1[6], exp_p1}) + 8'sd1 - $signed({3'b000, lz_c});
  assign grs_sig_c  = {norm_c[21:9], |norm_c[8:0]};

  fp16_round_pack u_round_pack (
    .sign      (sign_p1),
    .exp       (exp_norm_c),
    .sig       (grs_sig_c),
    .result    (rp_result),
    .overflow  (rp_ovf),
    .underflow (rp_unf),
    .inexact   (rp_inx)
  );

  // ---- stage 2: packed result and flags ----
  logic        vld_p2, inv_p2, ovf_p2, unf_p2, inx_p2;
  logic [15:0] out_p2;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      out_p2 <= '0;
      inv_p2 <= 1'b0;
      ovf_p2 <= 1'b0;
      unf_p2 <= 1'b0;
      inx_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        out_p2 <= spec_p1 ? spec_val_p1 : rp_result;
        inv_p2 <= spec_p1 & invalid_p1;
        ovf_p2 <= ~spec_p1 & rp_ovf;
        unf_p2 <= ~spec_p1 & rp_unf;
        inx_p2 <= ~spec_p1 & rp_inx;
      end
    end
  end

  assign bus.out_valid      = vld_p2;
  assign bus.out            = out_p2;
  assign bus.flag_invalid   = inv_p2;
  assign bus.flag_overflow  = ovf_p2;
  assign bus.flag_underflow = unf_p2;
  assign bus.flag_inexact   = inx_p2;
endmodule

// File: tb/tb_fp16_multiplier.sv
// Bench for fp16_multiplier: directed vector table, burst, randomized scoreboard, mid-flight reset.
module tb_fp16_multiplier;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fp16_multiplier_if bus();
  fp16_multiplier dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] out;
    logic [3:0]  flags;  // {invalid, overflow, underflow, inexact}
  } vec_t;

  vec_t tbl[16];
  logic [19:0] sbq[$];
  logic hist0, hist1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  function automatic logic [19:0] dut_word();
    return {bus.out, bus.flag_invalid, bus.flag_overflow, bus.flag_underflow, bus.flag_inexact};
  endfunction

  function automatic real pow2(input int k);
    real r;
    r = 1.0;
    if (k >= 0) repeat (k) r = r * 2.0;
    else repeat (-k) r = r / 2.0;
    return r;
  endfunction

  function automatic real mag(input logic [15:0] h);
    int e, f;
    e = int'(h[14:10]);
    f = int'(h[9:0]);
    if (e == 0) return f * pow2(-24);
    return (1024 + f) * pow2(e - 25);
  endfunction

  // Exact product in double precision, then rounded to binary16 by value.
  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b);
    logic s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inx, unf;
    real x, ulp, q, n, fr;
    int k, ni, ef, fv;
    s      = a[15] ^ b[15];
    a_nan  = (a[14:10] == 5'd31) && (a[9:0] != 10'd0);
    b_nan  = (b[14:10] == 5'd31) && (b[9:0] != 10'd0);
    a_inf  = (a[14:10] == 5'd31) && (a[9:0] == 10'd0);
    b_inf  = (b[14:10] == 5'd31) && (b[9:0] == 10'd0);
    a_zero = (a[14:0] == 15'd0);
    b_zero = (b[14:0] == 15'd0);
    if (a_nan || b_nan || (a_inf && b_zero) || (a_zero && b_inf)) return {16'h7E00, 4'b1000};
    if (a_inf || b_inf) return {s, 15'h7C00, 4'b0000};
    if (a_zero || b_zero) return {s, 15'h0000, 4'b0000};
    x = mag(a) * mag(b);
    k = 40;
    while (k > -14 && pow2(k) > x) k--;
    ulp = pow2(k - 10);
    q   = x / ulp;
    n   = $floor(q);
    fr  = q - n;
    ni  = int'(n);
    if (fr > 0.5 || (fr == 0.5 && ni % 2 == 1)) ni++;
    inx = (fr != 0.0);
    if (ni == 2048) begin
      ni = 1024;
      k++;
    end
    if (ni < 1024) begin
      ef = 0;
      fv = ni;
    end else begin
      ef = k + 15;
      fv = ni - 1024;
    end
    if (ef >= 31) return {s, 15'h7C00, 4'b0101};
    unf = inx && (ef == 0);
    return {s, 5'(ef), 10'(fv), 2'b00, unf, inx};
  endfunction

  function automatic logic [15:0] rand_op();
    logic [15:0] v;
    v = 16'($urandom);
    case ($urandom_range(0, 7))
      0: v[14:10] = 5'd0;
      1: begin
        v[14:10] = 5'd31;
        if (v[0]) v[9:0] = 10'd0;
      end
      2: v[14:10] = 5'(28 + $urandom_range(0, 2));
      3: v[14:0] = 15'd0;
      4: v = 16'($urandom);
      default: v[14:10] = 5'(8 + $urandom_range(0, 14));
    endcase
    return v;
  endfunction

  initial begin
    tbl[0]  = '{16'h3800, 16'h3800, 16'h3400, 4'b0000};
    tbl[1]  = '{16'hC100, 16'h3D00, 16'hC240, 4'b0000};
    tbl[2]  = '{16'hC100, 16'hBD00, 16'h4240, 4'b0000};
    tbl[3]  = '{16'h7BFF, 16'h4000, 16'h7C00, 4'b0101};
    tbl[4]  = '{16'h7C00, 16'h0000, 16'h7E00, 4'b1000};
    tbl[5]  = '{16'h7E00, 16'h3C00, 16'h7E00, 4'b1000};
    tbl[6]  = '{16'h0400, 16'h3800, 16'h0200, 4'b0000};
    tbl[7]  = '{16'h0001, 16'h3C00, 16'h0001, 4'b0000};
    tbl[8]  = '{16'h0001, 16'h3800, 16'h0000, 4'b0011};
    tbl[9]  = '{16'h3C01, 16'h3C01, 16'h3C02, 4'b0001};
    tbl[10] = '{16'h7C00, 16'hC000, 16'hFC00, 4'b0000};
    tbl[11] = '{16'h8000, 16'h3C00, 16'h8000, 4'b0000};
    tbl[12] = '{16'h3BFF, 16'h0400, 16'h0400, 4'b0001};
    tbl[13] = '{16'h7BFF, 16'h3C01, 16'h7C00, 4'b0101};
    tbl[14] = '{16'h0001, 16'h0001, 16'h0000, 4'b0011};
    tbl[15] = '{16'hFC00, 16'hFE01, 16'h7E00, 4'b1000};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out", 32'(bus.out), 32'h0);
    check("reset_flags", 32'(dut_word() & 20'hF), 32'h0);
    rst = 1'b0;

    // Isolated vectors: result must appear exactly two cycles after issue.
    for (int i = 0; i < 16; i++) begin
      bus.in_valid = 1'b1;
      bus.a = tbl[i].a;
      bus.b = tbl[i].b;
      @(negedge clk);
      bus.in_valid = 1'b0;
      check($sformatf("vec%0d_early", i), 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d_result", i), 32'(dut_word()), 32'({tbl[i].out, tbl[i].flags}));
    end

    // Back-to-back burst of 8.
    for (int c = 0; c < 10; c++) begin
      if (c >= 2) begin
        check($sformatf("burst%0d_valid", c - 2), 32'(bus.out_valid), 32'd1);
        check($sformatf("burst%0d_result", c - 2), 32'(dut_word()),
              32'({tbl[c - 2].out, tbl[c - 2].flags}));
      end
      bus.in_valid = (c < 8);
      bus.a = tbl[c % 16].a;
      bus.b = tbl[c % 16].b;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);

    // Randomized stream with scoreboard.
    hist0 = 1'b0;
    hist1 = 1'b0;
    for (int c = 0; c < 402; c++) begin
      check($sformatf("rand%0d_valid", c), 32'(bus.out_valid), 32'(hist1));
      if (bus.out_valid) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rand%0d_unexpected: got %h expected none", c, dut_word());
        end else begin
          logic [19:0] want;
          want = sbq.pop_front();
          check($sformatf("rand%0d_result", c), 32'(dut_word()), 32'(want));
        end
      end
      hist1 = hist0;
      bus.in_valid = (c < 400) && ($urandom_range(0, 3) != 0);
      bus.a = rand_op();
      bus.b = rand_op();
      if (bus.in_valid) sbq.push_back(model(bus.a, bus.b));
      hist0 = bus.in_valid;
      @(negedge clk);
    end
    check("rand_drained", 32'(sbq.size()), 32'd0);

    // Reset while two operations are in flight.
    bus.in_valid = 1'b1;
    bus.a = tbl[1].a;
    bus.b = tbl[1].b;
    @(negedge clk);
    bus.a = tbl[2].a;
    bus.b = tbl[2].b;
    @(negedge clk);
    rst = 1'b1;
    bus.a = tbl[9].a;
    bus.b = tbl[9].b;
    @(negedge clk);
    check("rst_flush_valid", 32'(bus.out_valid), 32'd0);
    check("rst_flush_out", 32'(bus.out), 32'h0);
    check("rst_flush_flags", 32'(dut_word() & 20'hF), 32'h0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("rst_stale%0d", c), 32'(bus.out_valid), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
